// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS frame sequencer: states, sync codes,
// field width and the word packing helper.
package lvds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREPARE  = 2'd1,
    ST_TRANSMIT = 2'd2,
    ST_TERM     = 2'd3
  } state_t;

  localparam int          FIELD_W   = 13;
  localparam logic [1:0]  SYNC_HI   = 2'b10;
  localparam logic [1:0]  SYNC_LO   = 2'b01;
  localparam logic [31:0] TERM_WORD = {SYNC_HI, 14'b0, SYNC_LO, 14'b0};

  // Fields arrive already left-justified to FIELD_W bits.
  function automatic logic [31:0] pack_word(input logic [FIELD_W-1:0] i_f,
                                            input logic [FIELD_W-1:0] q_f);
    return {SYNC_HI, i_f, 1'b1, SYNC_LO, q_f, 1'b0};
  endfunction

endpackage

// File: rtl/lvds_frame_seq_if.sv
// Sample stream into the frame sequencer (valid/ready with I, Q and last).
interface lvds_frame_seq_if #(
  parameter int SAMPLE_W = 13
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_i;
  logic [SAMPLE_W-1:0] s_q;
  logic                s_last;

  modport master (output s_valid, output s_i, output s_q, output s_last, input s_ready);
  modport slave  (input s_valid, input s_i, input s_q, input s_last, output s_ready);
endinterface

// File: rtl/lvds_sample_fifo.sv
// Small sample FIFO with show-ahead read and synchronous flush; the flush
// takes priority over a push in the same cycle.
module lvds_sample_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Show-ahead read so the sequencer can pack the word in the pop slot.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/lvds_frame_seq.sv
// Paces buffered I/Q samples into 32-bit serializer words, one word per
// tx_done rising edge, framed by PREPARE slots and closed by a terminator.
module lvds_frame_seq
  import lvds_pkg::*;
#(
  parameter int SAMPLE_W   = 13,
  parameter int PACE_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                transmit,
  input  logic                burst_mode,
  input  logic                tx_done,
  lvds_frame_seq_if.slave     s,
  output logic [31:0]         tx_data,
  output logic                busy,
  output logic                msg_done,
  output logic [7:0]          underrun_cnt
);

  localparam int            FW        = 2 * SAMPLE_W + 1;
  localparam int            PACE_W    = $clog2(PACE_DIV);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(PACE_DIV - 2);

  state_t              state_reg, state_next;
  logic [PACE_W-1:0]   pace_reg, pace_next;
  logic [31:0]         tx_data_reg, tx_data_next;
  logic [7:0]          underrun_reg, underrun_next;
  logic                msg_done_reg, msg_done_next;
  logic                start_pend_reg, start_pend_next;
  logic                burst_reg, burst_next;
  logic                last_reg, last_next;
  logic                tx_done_d;
  logic                transmit_d;

  logic                slot;
  logic                tx_rise;
  logic                fifo_full, fifo_empty, fifo_pop, fifo_flush;
  logic [FW-1:0]       fifo_rd;
  logic [SAMPLE_W-1:0] rd_i, rd_q;
  logic                rd_last;
  logic [FIELD_W-1:0]  i_field, q_field;

  assign slot    = tx_done & ~tx_done_d;
  assign tx_rise = transmit & ~transmit_d;

  assign s.s_ready = ~fifo_full;

  lvds_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .push    (s.s_valid & ~fifo_full),
    .wr_data ({s.s_last, s.s_q, s.s_i}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {rd_last, rd_q, rd_i} = fifo_rd;
  // Narrow samples sit in the MSBs of the 13-bit field.
  assign i_field = FIELD_W'(rd_i) << (FIELD_W - SAMPLE_W);
  assign q_field = FIELD_W'(rd_q) << (FIELD_W - SAMPLE_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      pace_reg       <= '0;
      tx_data_reg    <= '0;
      underrun_reg   <= '0;
      msg_done_reg   <= 1'b0;
      start_pend_reg <= 1'b0;
      burst_reg      <= 1'b0;
      last_reg       <= 1'b0;
      tx_done_d      <= 1'b0;
      transmit_d     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pace_reg       <= pace_next;
      tx_data_reg    <= tx_data_next;
      underrun_reg   <= underrun_next;
      msg_done_reg   <= msg_done_next;
      start_pend_reg <= start_pend_next;
      burst_reg      <= burst_next;
      last_reg       <= last_next;
      tx_done_d      <= tx_done;
      transmit_d     <= transmit;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pace_next       = pace_reg;
    tx_data_next    = tx_data_reg;
    underrun_next   = underrun_reg;
    msg_done_next   = 1'b0;
    start_pend_next = start_pend_reg;
    burst_next      = burst_reg;
    last_next       = last_reg;
    fifo_pop        = 1'b0;
    fifo_flush      = 1'b0;

    // Requests are only latched while idle; mid-message edges are dropped.
    if (state_reg == ST_IDLE && tx_rise) begin
      start_pend_next = 1'b1;
    end

    if (slot) begin
      case (state_reg)
        ST_IDLE: begin
          tx_data_next = '0;
          if (start_pend_reg) begin
            start_pend_next = 1'b0;
            pace_next       = '0;
            burst_next      = burst_mode;
            underrun_next   = '0;
            state_next      = ST_PREPARE;
          end
        end
        ST_PREPARE: begin
          tx_data_next = '0;
          pace_next    = pace_reg + 1'b1;
          if (pace_reg == PACE_LAST) begin
            if (!fifo_empty) begin
              fifo_pop     = 1'b1;
              tx_data_next = pack_word(i_field, q_field);
              last_next    = rd_last;
              state_next   = ST_TRANSMIT;
            end else begin
              // Starved frame: restart the frame and count it.
              pace_next = '0;
              if (underrun_reg != 8'hFF) underrun_next = underrun_reg + 8'd1;
            end
          end
        end
        ST_TRANSMIT: begin
          if ((last_reg && burst_reg) || (!transmit && !burst_reg)) begin
            tx_data_next  = TERM_WORD;
            msg_done_next = 1'b1;
            state_next    = ST_TERM;
          end else begin
            tx_data_next = '0;
            pace_next    = '0;
            state_next   = ST_PREPARE;
          end
        end
        ST_TERM: begin
          tx_data_next = '0;
          fifo_flush   = 1'b1;
          state_next   = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign tx_data      = tx_data_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign msg_done     = msg_done_reg;
  assign underrun_cnt = underrun_reg;

endmodule
